// File: rtl/s_block_writeback_pkg.sv
// Shared block-level state types and constants for the decode pipeline.
// The writeback origin helper folds the block coordinates into one SRAM
// word address so the per-cycle path only ever adds small offsets.
package s_block_writeback_pkg;

    typedef enum logic [2:0] {
        S_WB_IDLE,
        S_WB_LI,
        S_WB_CC,
        S_WB_LO,
        S_WB_DONE
    } WB_state_type;

    localparam int BLOCK_DIM = 8;
    localparam int PIX_MAX   = 255;

    // SRAM word address of pixel (0,0) of block (row_blk, col_blk); wraps mod 2^18
    function automatic logic [17:0] wb_origin(input logic [17:0] base,
                                              input logic [4:0]  row_blk,
                                              input logic [5:0]  col_blk,
                                              input int          words_per_row);
        return base
             + 18'(row_blk) * 18'(BLOCK_DIM * words_per_row)
             + {10'd0, col_blk, 2'b00};
    endfunction

endpackage

// File: rtl/s_block_writeback_if.sv
// Bundle of the writeback block's start/done handshake, DPRAM read port
// and SRAM write port. The block itself uses the slave view; the
// controlling FSM / memories use the master view.
interface s_block_writeback_if;
    logic        WB_start;
    logic        WB_done;
    logic [4:0]  row_blk;
    logic [5:0]  col_blk;
    logic [17:0] sram_base;
    logic [6:0]  RAM_read_address;
    logic [31:0] RAM_read_data;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    modport master (
        output WB_start, row_blk, col_blk, sram_base, RAM_read_data,
        input  WB_done, RAM_read_address, SRAM_address, SRAM_write_data, SRAM_we_n
    );

    modport slave (
        input  WB_start, row_blk, col_blk, sram_base, RAM_read_data,
        output WB_done, RAM_read_address, SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/s_block_writeback_pixel_clip.sv
// Scales a signed 32-bit fixed-point result down by SHIFT (arithmetic)
// and clamps it to an unsigned 8-bit pixel. Purely combinational.
module pixel_clip
    import s_block_writeback_pkg::*;
#(
    parameter int SHIFT = 16
) (
    input  logic signed [31:0] i_data,
    output logic        [7:0]  o_pix
);

    logic signed [31:0] w_shifted;

    assign w_shifted = i_data >>> SHIFT;

    // Clamp below zero and above full scale, otherwise pass the low byte
    always_comb begin
        o_pix = w_shifted[7:0];
        if (w_shifted < 0)
            o_pix = 8'd0;
        else if (w_shifted > PIX_MAX)
            o_pix = 8'(PIX_MAX);
    end

endmodule

// File: rtl/s_block_writeback.sv
// Streams one 8x8 result block out of the DPRAM, scales/clips each value
// to a pixel and writes pixel pairs to SRAM. Timing is fixed: reads in
// cycles 1..64, writes every other cycle 4..66, done pulse in cycle 67.
// r_cnt holds the current cycle number while a block is in flight.
module s_block_writeback
    import s_block_writeback_pkg::*;
#(
    parameter logic [6:0] RD_BASE       = 7'd0,
    parameter int         SHIFT         = 16,
    parameter int         WORDS_PER_ROW = 160
) (
    input logic                CLOCK_50_I,
    input logic                Resetn,
    s_block_writeback_if.slave wb
);

    localparam logic [6:0] CYC_LI_END    = 7'd2;
    localparam logic [6:0] CYC_RD_LAST   = 7'd63;
    localparam logic [6:0] CYC_CAP_FIRST = 7'd2;
    localparam logic [6:0] CYC_CAP_LAST  = 7'd65;
    localparam logic [6:0] CYC_WR_END    = 7'd66;

    WB_state_type r_state;
    logic [6:0]   r_cnt;
    logic         r_armed;
    logic [6:0]   r_rd_addr;
    logic [17:0]  r_sram_addr;
    logic [15:0]  r_wdata;
    logic         r_we_n;
    logic         r_done;
    logic [17:0]  r_row_base;
    logic [7:0]   r_even;

    logic         w_start;
    logic         w_cap;
    logic [2:0]   w_col;
    logic [6:0]   w_rd_next;
    logic [7:0]   w_pix;

    // Start is only honoured in idle and never on the first edge after reset
    assign w_start   = (r_state == S_WB_IDLE) && wb.WB_start && r_armed;
    // Data for element n sits on the read port at the edge ending cycle n+2
    assign w_cap     = ((r_state == S_WB_LI) || (r_state == S_WB_CC) || (r_state == S_WB_LO))
                       && (r_cnt >= CYC_CAP_FIRST) && (r_cnt <= CYC_CAP_LAST);
    assign w_col     = r_cnt[2:0] - 3'd2;
    // Low 6 address bits wrap inside the 64-entry product region
    assign w_rd_next = {RD_BASE[6], RD_BASE[5:0] + r_cnt[5:0]};

    pixel_clip #(.SHIFT(SHIFT)) u_pixel_clip (
        .i_data (wb.RAM_read_data),
        .o_pix  (w_pix)
    );

    // Sequencer: state, cycle counter, read address and registered SRAM port
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_state     <= S_WB_IDLE;
            r_cnt       <= 7'd0;
            r_armed     <= 1'b0;
            r_rd_addr   <= RD_BASE;
            r_sram_addr <= 18'd0;
            r_wdata     <= 16'd0;
            r_we_n      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            r_we_n  <= 1'b1;
            r_done  <= 1'b0;

            if (w_cap && w_col[0]) begin
                r_we_n      <= 1'b0;
                r_wdata     <= {r_even, w_pix};
                r_sram_addr <= r_row_base + 18'(w_col[2:1]);
            end

            case (r_state)
                S_WB_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_WB_LI;
                        r_cnt     <= 7'd1;
                        r_rd_addr <= RD_BASE;
                    end
                end
                S_WB_LI: begin
                    r_cnt     <= r_cnt + 7'd1;
                    r_rd_addr <= w_rd_next;
                    if (r_cnt == CYC_LI_END)
                        r_state <= S_WB_CC;
                end
                S_WB_CC: begin
                    r_cnt     <= r_cnt + 7'd1;
                    r_rd_addr <= w_rd_next;
                    if (r_cnt == CYC_RD_LAST)
                        r_state <= S_WB_LO;
                end
                S_WB_LO: begin
                    r_cnt <= r_cnt + 7'd1;
                    if (r_cnt == CYC_WR_END) begin
                        r_state <= S_WB_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_WB_DONE: begin
                    r_state <= S_WB_IDLE;
                    r_cnt   <= 7'd0;
                end
                default: begin
                    r_state <= S_WB_IDLE;
                    r_cnt   <= 7'd0;
                end
            endcase
        end
    end

    // Datapath: row origin (multiply only at start, then stepped) and even-pixel hold
    always_ff @(posedge CLOCK_50_I) begin
        if (w_start)
            r_row_base <= wb_origin(wb.sram_base, wb.row_blk, wb.col_blk, WORDS_PER_ROW);
        else if (w_cap && (w_col == 3'd7))
            r_row_base <= r_row_base + 18'(WORDS_PER_ROW);

        if (w_cap && !w_col[0])
            r_even <= w_pix;
    end

    assign wb.RAM_read_address = r_rd_addr;
    assign wb.SRAM_address     = r_sram_addr;
    assign wb.SRAM_write_data  = r_wdata;
    assign wb.SRAM_we_n        = r_we_n;
    assign wb.WB_done          = r_done;

endmodule

// File: tb/tb_s_block_writeback.sv
// Bench for s_block_writeback: registered DPRAM model, negedge monitor of
// SRAM writes / done pulses tagged with cycle number relative to start,
// and a direct reference model of the expected 32 writes.
module tb_s_block_writeback;

    logic CLOCK_50_I = 1'b0;
    logic Resetn;

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    s_block_writeback_if wbif();

    s_block_writeback #(
        .RD_BASE       (7'd0),
        .SHIFT         (16),
        .WORDS_PER_ROW (160)
    ) dut (
        .CLOCK_50_I (CLOCK_50_I),
        .Resetn     (Resetn),
        .wb         (wbif)
    );

    logic [31:0] mem [64];
    int          edge_cnt = 0;
    int          e0 = 0;
    int          errors = 0;
    int          checks = 0;
    logic [65:0] wr_q  [$];
    logic [65:0] exp_q [$];
    int          done_q[$];

    // Registered-output DPRAM: data one cycle after address
    always @(posedge CLOCK_50_I) wbif.RAM_read_data <= mem[wbif.RAM_read_address[5:0]];

    always @(posedge CLOCK_50_I) edge_cnt++;

    // Monitor away from the active edge; cycle k is the one after edge e0+k-1
    always @(negedge CLOCK_50_I) begin
        if (Resetn) begin
            if (!wbif.SRAM_we_n)
                wr_q.push_back({32'(edge_cnt - e0 + 1), wbif.SRAM_address, wbif.SRAM_write_data});
            if (wbif.WB_done)
                done_q.push_back(edge_cnt - e0 + 1);
        end
    end

    function automatic logic [7:0] ref_clip(input logic [31:0] x);
        int v;
        v = int'($signed(x)) >>> 16;
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    // Expected writes: pair j of row r is pixels (r, 2j) and (r, 2j+1), in cycle off+2k+4
    task automatic build_exp(input logic [17:0] base, input logic [4:0] rb,
                             input logic [5:0] cb, input int off);
        for (int k = 0; k < 32; k++) begin
            int r, j;
            logic [17:0] a;
            r = k / 4;
            j = k % 4;
            a = 18'(int'(base) + (int'(rb) * 8 + r) * 160 + int'(cb) * 4 + j);
            exp_q.push_back({32'(off + 2 * k + 4), a,
                             ref_clip(mem[8 * r + 2 * j]), ref_clip(mem[8 * r + 2 * j + 1])});
        end
    endtask

    function automatic logic [31:0] rand_result();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return (32'($urandom_range(0, 255)) << 16) | ($urandom & 32'hFFFF);
            2:       return 32'(-($urandom_range(1, 1000) * 65536));
            default: return 32'($urandom_range(256, 5000)) << 16;
        endcase
    endfunction

    // Start a block, optionally re-pulse WB_start in given cycles, run n_cyc cycles
    task automatic run_block(input logic [17:0] base, input logic [4:0] rb,
                             input logic [5:0] cb, input int p1, input int p2, input int n_cyc);
        wr_q.delete();
        done_q.delete();
        exp_q.delete();
        @(negedge CLOCK_50_I);
        wbif.sram_base = base;
        wbif.row_blk   = rb;
        wbif.col_blk   = cb;
        wbif.WB_start  = 1'b1;
        e0 = edge_cnt + 1;
        @(negedge CLOCK_50_I);
        wbif.WB_start  = 1'b0;
        wbif.sram_base = 18'($urandom);
        wbif.row_blk   = 5'($urandom_range(0, 29));
        wbif.col_blk   = 6'($urandom_range(0, 39));
        for (int c = 1; c <= n_cyc; c++) begin
            wbif.WB_start = (c == p1) || (c == p2);
            @(negedge CLOCK_50_I);
        end
        wbif.WB_start = 1'b0;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        wbif.WB_start = 1'b0; wbif.sram_base = '0; wbif.row_blk = '0; wbif.col_blk = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        repeat (3) @(negedge CLOCK_50_I);
        checks++; if (wbif.WB_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", wbif.WB_done); end
        checks++; if (wbif.SRAM_we_n !== 1'b1) begin errors++; $display("FAIL rst_we_n: got %b want 1", wbif.SRAM_we_n); end
        checks++; if (wbif.SRAM_address !== 18'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", wbif.SRAM_address); end
        checks++; if (wbif.SRAM_write_data !== 16'd0) begin errors++; $display("FAIL rst_wdata: got %h want 0000", wbif.SRAM_write_data); end
        checks++; if (wbif.RAM_read_address !== 7'd0) begin errors++; $display("FAIL rst_rdaddr: got %0d want 0", wbif.RAM_read_address); end
        Resetn = 1'b1;
        repeat (3) @(negedge CLOCK_50_I);
        checks++; if (wbif.SRAM_we_n !== 1'b1 || wbif.WB_done !== 1'b0)
            begin errors++; $display("FAIL idle_after_rst: got we_n=%b done=%b want 1/0", wbif.SRAM_we_n, wbif.WB_done); end
    endtask

    task automatic test_zero();
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        run_block(18'd0, 5'd0, 6'd0, 0, 0, 75);
        build_exp(18'd0, 5'd0, 6'd0, 0);
        checks++; if (wr_q.size() != 32) begin errors++; $display("FAIL zero_count: got %0d writes want 32", wr_q.size()); end
        for (int i = 0; i < 32 && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL zero_wr%0d: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h", i,
                         wr_q[i][65:34], wr_q[i][33:16], wr_q[i][15:0], exp_q[i][65:34], exp_q[i][33:16], exp_q[i][15:0]); end
        end
        checks++; if (wr_q.size() == 32 && wr_q[31][33:16] !== 18'd1123) begin errors++; $display("FAIL zero_last_addr: got %0d want 1123", wr_q[31][33:16]); end
        checks++; if (done_q.size() != 1 || done_q[0] != 67)
            begin errors++; $display("FAIL zero_done: got %0d pulses first=%0d want 1 at 67", done_q.size(), done_q.size() ? done_q[0] : -1); end
    endtask

    task automatic test_clip();
        for (int i = 0; i < 64; i++) mem[i] = rand_result();
        mem[0] = 32'hFFFF_0000; mem[1] = 32'h012C_0000; mem[2] = 32'h0080_0000; mem[3] = 32'h00FF_FFFF;
        run_block(18'd500, 5'd1, 6'd2, 0, 0, 75);
        build_exp(18'd500, 5'd1, 6'd2, 0);
        checks++; if (wr_q.size() != 32) begin errors++; $display("FAIL clip_count: got %0d writes want 32", wr_q.size()); end
        checks++; if (wr_q.size() > 1 && (wr_q[0][15:0] !== 16'h00FF || wr_q[1][15:0] !== 16'h80FF))
            begin errors++; $display("FAIL clip_words: got %h %h want 00ff 80ff", wr_q[0][15:0], wr_q[1][15:0]); end
        for (int i = 0; i < 32 && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL clip_wr%0d: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h", i,
                         wr_q[i][65:34], wr_q[i][33:16], wr_q[i][15:0], exp_q[i][65:34], exp_q[i][33:16], exp_q[i][15:0]); end
        end
    endtask

    task automatic test_ramp();
        logic [17:0] base;
        base = 18'($urandom_range(0, 100000));
        for (int i = 0; i < 64; i++) mem[i] = 32'(i) << 16;
        run_block(base, 5'd0, 6'd0, 0, 0, 75);
        build_exp(base, 5'd0, 6'd0, 0);
        checks++; if (wr_q.size() != 32) begin errors++; $display("FAIL ramp_count: got %0d writes want 32", wr_q.size()); end
        checks++; if (wr_q.size() == 32 && ({wr_q[31][33:16], wr_q[31][15:0]} !== {18'(base + 18'd1123), 16'h3E3F}))
            begin errors++; $display("FAIL ramp_r7p3: got addr=%0d data=%h want addr=%0d data=3e3f", wr_q[31][33:16], wr_q[31][15:0], 18'(base + 18'd1123)); end
        for (int i = 0; i < 32 && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL ramp_wr%0d: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h", i,
                         wr_q[i][65:34], wr_q[i][33:16], wr_q[i][15:0], exp_q[i][65:34], exp_q[i][33:16], exp_q[i][15:0]); end
        end
    endtask

    task automatic test_addressing();
        for (int i = 0; i < 64; i++) mem[i] = rand_result();
        run_block(18'd1000, 5'd2, 6'd3, 0, 0, 75);
        checks++; if (wr_q.size() != 32) begin errors++; $display("FAIL addr_count: got %0d writes want 32", wr_q.size()); end
        checks++; if (wr_q.size() == 32 && (wr_q[0][33:16] !== 18'd3572 || wr_q[31][33:16] !== 18'd4695))
            begin errors++; $display("FAIL addr_first_last: got %0d %0d want 3572 4695", wr_q[0][33:16], wr_q[31][33:16]); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            logic [17:0] base; logic [4:0] rb; logic [5:0] cb;
            base = (t == 0) ? 18'h3FFF0 : 18'($urandom);
            rb   = (t == 0) ? 5'd29 : 5'($urandom_range(0, 29));
            cb   = (t == 0) ? 6'd39 : 6'($urandom_range(0, 39));
            for (int i = 0; i < 64; i++) mem[i] = rand_result();
            run_block(base, rb, cb, 0, 0, 75);
            build_exp(base, rb, cb, 0);
            checks++; if (wr_q.size() != 32) begin errors++; $display("FAIL rand%0d_count: got %0d writes want 32", t, wr_q.size()); end
            for (int i = 0; i < 32 && i < wr_q.size(); i++) begin
                checks++;
                if (wr_q[i] !== exp_q[i]) begin errors++;
                    $display("FAIL rand%0d_wr%0d: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h", t, i,
                             wr_q[i][65:34], wr_q[i][33:16], wr_q[i][15:0], exp_q[i][65:34], exp_q[i][33:16], exp_q[i][15:0]); end
            end
            checks++; if (done_q.size() != 1 || done_q[0] != 67)
                begin errors++; $display("FAIL rand%0d_done: got %0d pulses first=%0d want 1 at 67", t, done_q.size(), done_q.size() ? done_q[0] : -1); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 64; i++) mem[i] = rand_result();
        run_block(18'd2000, 5'd4, 6'd5, 10, 67, 75);
        build_exp(18'd2000, 5'd4, 6'd5, 0);
        checks++; if (wr_q.size() != 32) begin errors++; $display("FAIL ignore_count: got %0d writes want 32", wr_q.size()); end
        for (int i = 0; i < 32 && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL ignore_wr%0d: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h", i,
                         wr_q[i][65:34], wr_q[i][33:16], wr_q[i][15:0], exp_q[i][65:34], exp_q[i][33:16], exp_q[i][15:0]); end
        end
        checks++; if (done_q.size() != 1 || done_q[0] != 67)
            begin errors++; $display("FAIL ignore_done: got %0d pulses first=%0d want 1 at 67", done_q.size(), done_q.size() ? done_q[0] : -1); end

        run_block(18'd7, 5'd0, 6'd1, 67, 68, 140);
        build_exp(18'd7, 5'd0, 6'd1, 0);
        build_exp(wbif.sram_base, wbif.row_blk, wbif.col_blk, 68);
        checks++; if (wr_q.size() != 64) begin errors++; $display("FAIL b2b_count: got %0d writes want 64", wr_q.size()); end
        for (int i = 0; i < 64 && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL b2b_wr%0d: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h", i,
                         wr_q[i][65:34], wr_q[i][33:16], wr_q[i][15:0], exp_q[i][65:34], exp_q[i][33:16], exp_q[i][15:0]); end
        end
        checks++; if (done_q.size() != 2 || done_q[0] != 67 || done_q[1] != 135)
            begin errors++; $display("FAIL b2b_done: got %0d pulses last=%0d want 2 ending at 135", done_q.size(), done_q.size() ? done_q[done_q.size() - 1] : -1); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 64; i++) mem[i] = rand_result();
        wr_q.delete(); done_q.delete(); exp_q.delete();
        @(negedge CLOCK_50_I);
        wbif.sram_base = 18'd300; wbif.row_blk = 5'd3; wbif.col_blk = 6'd7; wbif.WB_start = 1'b1;
        e0 = edge_cnt + 1;
        @(negedge CLOCK_50_I);
        wbif.WB_start = 1'b0;
        repeat (29) @(negedge CLOCK_50_I);
        checks++; if (wbif.SRAM_we_n !== 1'b0) begin errors++; $display("FAIL mid_we_before: got %b want 0 in cycle 30", wbif.SRAM_we_n); end
        Resetn = 1'b0;
        #1;
        checks++; if (wbif.SRAM_we_n !== 1'b1 || wbif.WB_done !== 1'b0)
            begin errors++; $display("FAIL mid_rst_outputs: got we_n=%b done=%b want 1/0", wbif.SRAM_we_n, wbif.WB_done); end
        @(negedge CLOCK_50_I);
        Resetn = 1'b1;
        repeat (2) @(negedge CLOCK_50_I);
        wr_q.delete(); done_q.delete();
        repeat (80) @(negedge CLOCK_50_I);
        checks++; if (wr_q.size() != 0 || done_q.size() != 0)
            begin errors++; $display("FAIL mid_no_resume: got %0d writes %0d dones want 0 0", wr_q.size(), done_q.size()); end
        run_block(18'd300, 5'd3, 6'd7, 0, 0, 75);
        build_exp(18'd300, 5'd3, 6'd7, 0);
        checks++; if (wr_q.size() != 32) begin errors++; $display("FAIL mid_restart_count: got %0d writes want 32", wr_q.size()); end
        for (int i = 0; i < 32 && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL mid_wr%0d: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h", i,
                         wr_q[i][65:34], wr_q[i][33:16], wr_q[i][15:0], exp_q[i][65:34], exp_q[i][33:16], exp_q[i][15:0]); end
        end
        checks++; if (done_q.size() != 1 || done_q[0] != 67)
            begin errors++; $display("FAIL mid_restart_done: got %0d pulses first=%0d want 1 at 67", done_q.size(), done_q.size() ? done_q[0] : -1); end
    endtask

    task automatic test_start_at_release();
        @(negedge CLOCK_50_I);
        Resetn = 1'b0;
        @(negedge CLOCK_50_I);
        wr_q.delete(); done_q.delete();
        Resetn = 1'b1;
        wbif.WB_start = 1'b1;
        @(negedge CLOCK_50_I);
        wbif.WB_start = 1'b0;
        repeat (80) @(negedge CLOCK_50_I);
        checks++; if (wr_q.size() != 0 || done_q.size() != 0)
            begin errors++; $display("FAIL release_start: got %0d writes %0d dones want 0 0", wr_q.size(), done_q.size()); end
        run_block(18'd0, 5'd0, 6'd0, 0, 0, 75);
        checks++; if (done_q.size() != 1 || done_q[0] != 67)
            begin errors++; $display("FAIL release_then_start: got %0d pulses first=%0d want 1 at 67", done_q.size(), done_q.size() ? done_q[0] : -1); end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_clip();
        test_ramp();
        test_addressing();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_start_at_release();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/s_block_writeback.md
Name: s_block_writeback

Overview:
- Reads one finished 8x8 result block (S) from the embedded dual-port RAM that the matrix multiplier fills, and writes it to external SRAM.
- Each of the 64 signed 32-bit results is scaled, clipped to 8 bits, and packed two pixels per 16-bit word.
- Sits downstream of the matrix multiplier in the decode pipeline. It is the reader of the product region that the multiplier writes.
- The top-level FSM starts it with a pulse and waits for its done pulse before reusing the RAM region.

Parameters:
- RD_BASE, 7'd0: DPRAM address of result element 0. Results are stored row-major: index = r*8 + c.
- SHIFT, 16: arithmetic right-shift applied to each 32-bit result before clipping.
- WORDS_PER_ROW, 160: SRAM words per image row (320 pixels / 2).

Ports:
- CLOCK_50_I  in  1  system clock, 50 MHz.
- Resetn  in  1  asynchronous reset, active-low.
- WB_start  in  1  one-cycle start pulse; sampled only in S_WB_IDLE.
- WB_done  out  1  one-cycle pulse after the last SRAM write.
- row_blk  in  5  block row index (0..29); latched at start.
- col_blk  in  6  block column index (0..39); latched at start.
- sram_base  in  18  SRAM word address of the plane origin; latched at start.
- RAM_read_address  out  7  DPRAM read address.
- RAM_read_data  in  32  DPRAM read data; valid one cycle after the address.
- SRAM_address  out  18  SRAM word address.
- SRAM_write_data  out  16  packed pixels: {pixel 2k in [15:8], pixel 2k+1 in [7:0]}.
- SRAM_we_n  out  1  SRAM write enable, active-low.

Behaviour:
- Reset values (applies at any time, including mid-block):
  - WB_done=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, RAM_read_address=RD_BASE.
  - State returns to S_WB_IDLE; all counters cleared.
  - No partial write continues after reset deasserts.
- States: S_WB_IDLE, S_WB_LI, S_WB_CC, S_WB_LO, S_WB_DONE.
- S_WB_IDLE:
  - On WB_start=1 at edge 0: latch row_blk, col_blk, sram_base; present RAM_read_address=RD_BASE; go to S_WB_LI.
  - WB_start is ignored in every other state.
- Reads: RAM_read_address steps RD_BASE+0 .. RD_BASE+63, one per cycle, in cycles 1..64. The low 6 bits wrap mod 64 within the region.
- Pixel pipeline: data for index n is captured at the end of cycle n+2, producing pixel p = clip(data >>> SHIFT).
  - The shift is signed arithmetic.
  - clip: <0 -> 8'd0; >255 -> 8'd255; otherwise the low 8 bits.
- Even pixel: held in a register.
- Odd pixel 2k+1: the same edge registers SRAM_write_data={even,odd}, SRAM_we_n=0 and SRAM_address. SRAM_we_n is low during cycle 2k+4, k=0..31.
- SRAM_we_n returns to 1 in cycles where no odd pair completes. Writes occur every other cycle, 32 in total.
- SRAM address for pixel (r, c): sram_base + (row_blk*8 + r)*WORDS_PER_ROW + col_blk*4 + c/2, modulo 2^18.
  - A row base register is computed at start.
  - It advances by WORDS_PER_ROW when r increments.
  - No multiplier is used in the per-cycle path.
- State timing:
  - S_WB_LI covers cycles 1-2.
  - S_WB_CC runs until the last read (index 63) is issued.
  - S_WB_LO drains until the final write (cycle 66).
  - S_WB_DONE pulses WB_done=1 in cycle 67, then returns to S_WB_IDLE.
- A new WB_start is accepted in cycle 68 at the earliest.
- Total latency from start to done: 67 cycles, fixed and data-independent.
- A start coincident with reset deassertion is ignored.

Decomposition:
- State enum WB_state_type goes in the shared state header/package alongside the other block state types.
- Add the shared constants BLOCK_DIM=8 and PIX_MAX=255 to the same package.
- One natural sub-module: pixel_clip. It is combinational: 32-bit signed in, SHIFT parameter, 8-bit clipped out. It is instantiated once and reused by the colour-conversion path.

Test Plan:
1. All 64 results = 0, sram_base=0, row_blk=0, col_blk=0 -> 32 writes of 16'h0000 to addresses 0,1,2,3,160,...,1123; WB_done high in cycle 67 only.
2. Clipping: result[0]=32'hFFFF_0000 (-1.0), result[1]=32'h012C_0000 (300), result[2]=32'h0080_0000 (128), result[3]=32'h00FF_FFFF (255) -> word0=16'h00FF, word1=16'h80FF.
3. Ramp: result[n]=n<<16 -> word at row r, pair j = {8r+2j, 8r+2j+1}; e.g. address base+160*7+3 holds 16'h3E3F.
4. Addressing: sram_base=18'd1000, row_blk=2, col_blk=3 -> first write address 1000+16*160+12=3572, last 3572+7*160+3=4695.
5. Reset mid-block: assert Resetn=0 during cycle 30 -> SRAM_we_n=1 immediately, no WB_done; a fresh start then completes normally with 67-cycle latency.
6. WB_start re-pulsed at cycle 10 and cycle 67 -> both ignored, exactly 32 writes; a start at cycle 68 is accepted.
